md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers; sits in the E stage beside the ALU.
- Accepts one MD operation per start pulse, holds busy for a fixed latency, then commits the result to HI/LO.
- Exposes busy so the hazard unit stalls D-stage MD instructions while an operation is in flight.
- Also services MTHI/MTLO writes and drives HI/LO for MFHI/MFLO.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (1..15)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low (0 = reset asserted, sampled on clk rising edge)
- a  input  32  rs operand, E stage
- b  input  32  rt operand, E stage
- mdop  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- start  input  1  qualifies mdop this cycle
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset==0 at edge): hi=0, lo=0, busy=0, state=IDLE, counter=0, operand latches=0. Takes priority over everything, including an op in flight, which is aborted with no HI/LO write.
- States:
  - IDLE
  - RUN_MUL
  - RUN_DIV
- IDLE, start=1, mdop in 1..4 at edge t:
  - latch a, b, and the signed/unsigned flag
  - load counter with MUL_CYCLES or DIV_CYCLES
  - go to RUN_MUL or RUN_DIV; busy=1 from cycle t+1
- RUN_x: counter decrements each edge. On the edge where counter==1:
  - commit result to HI/LO
  - busy=0, return to IDLE
  - busy is high for exactly N cycles (t+1..t+N); new hi/lo are visible from cycle t+N+1.
- MULT: {hi,lo} = signed 64-bit product of latched a and b. MULTU: same, unsigned.
- DIV: lo = signed quotient, truncated toward zero; hi = remainder, sign of dividend. DIVU: unsigned.
- Divide by zero (latched b==0): full DIV_CYCLES busy period still runs; HI and LO are left unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO, IDLE, start=1: hi (or lo) <= a at that edge; busy stays 0; no state change.
- start=1 while busy (any mdop): ignored, no effect on state, operands, HI, or LO. The hazard unit prevents this case; the block must still be robust to it.
- start=1 with mdop NONE or 7: no effect.
- The commit edge and a new start on the same edge cannot coincide, because start is ignored while busy. A start on the first IDLE cycle after commit is accepted normally (back-to-back ops, zero gap).
- hi/lo are direct register outputs; no combinational path from inputs to outputs.
- busy is a registered output.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=2 -> lo=3, hi=1.
- Preload MTHI a=0x1234, MTLO a=0x5678; DIVU a=7, b=0 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
- Start MULT 3*4, and on cycle 2 of busy pulse start with MTLO a=0xDEAD -> MTLO ignored; busy still ends after 5 cycles; hi=0, lo=0xC.
- Start DIV 100/7, drive reset=0 on busy cycle 4 -> next edge busy=0, hi=lo=0. Then MULT 2*3 is accepted normally: lo=6 after 5 cycles.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
//   Multi-cycle multiply/divide unit with HI/LO registers, placed in the
//   E stage beside the ALU. One MD operation is accepted per start pulse
//   while idle. busy is held for a fixed latency, then the result is
//   committed to HI/LO. MTHI/MTLO writes complete in a single edge while idle.
//
// Ports
//   clk    : clock; all state updates on the rising edge
//   reset  : synchronous reset, active low
//   a, b   : rs / rt operands (E stage)
//   mdop   : 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   start  : qualifies mdop this cycle
//   busy   : operation in flight (registered)
//   hi, lo : HI / LO registers (registered)
module md_unit_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  mdop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2
  } state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic        sgn_q,   sgn_d;
  logic        busy_q,  busy_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  // Multiply: operands are extended to 64 bits according to the signed flag;
  // the low 64 bits of the product are then correct for both MULT and MULTU.
  logic [63:0] mul_a, mul_b, prod;

  // Divide: divide magnitudes, then restore signs. Quotient truncates toward
  // zero and the remainder takes the dividend's sign. The most-negative /
  // -1 case wraps naturally to 0x80000000 with remainder 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    mul_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    mul_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod  = mul_a * mul_b;

    a_neg = sgn_q & a_q[31];
    b_neg = sgn_q & b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : '0;
    r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : '0;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (mdop)
            3'd1, 3'd2: begin
              state_d = RUN_MUL;
              cnt_d   = MUL_CNT;
              a_d     = a;
              b_d     = b;
              sgn_d   = (mdop == 3'd1);
              busy_d  = 1'b1;
            end
            3'd3, 3'd4: begin
              state_d = RUN_DIV;
              cnt_d   = DIV_CNT;
              a_d     = a;
              b_d     = b;
              sgn_d   = (mdop == 3'd3);
              busy_d  = 1'b1;
            end
            3'd5:    hi_d = a;
            3'd6:    lo_d = a;
            default: ;
          endcase
        end
      end

      RUN_MUL: begin
        if (cnt_q == 4'd1) begin
          {hi_d, lo_d} = prod;
          state_d      = IDLE;
          cnt_d        = '0;
          busy_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RUN_DIV: begin
        if (cnt_q == 4'd1) begin
          // Divide by zero runs the full latency but leaves HI/LO untouched.
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed testbench for md_unit_ctrl. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_md_unit_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  mdop;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_checks;
  int unsigned n_fail;

  md_unit_ctrl #(
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .mdop  (mdop),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts busy cycles; returns at the first idle cycle (bounded).
  task automatic wait_idle(output int unsigned cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Issue one op at the next rising edge, then count busy cycles after it.
  task automatic do_op(input logic [2:0] op, input logic [31:0] va,
                       input logic [31:0] vb, output int unsigned cycles);
    mdop  = op;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mdop  = 3'd0;
    wait_idle(cycles);
  endtask

  int unsigned cyc;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    start = 1'b0;
    mdop  = 3'd0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    // NONE and reserved opcodes have no effect.
    do_op(3'd0, 32'h1111_1111, 32'h2222_2222, cyc);
    do_op(3'd7, 32'h3333_3333, 32'h4444_4444, cyc);
    check("none_busy", cyc, 32'd0);
    check("none_hi", hi, 32'h0);
    check("none_lo", lo, 32'h0);

    do_op(3'd1, 32'hFFFF_FFFD, 32'd5, cyc);
    check("mult_busy", cyc, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, cyc);
    check("multu_busy", cyc, 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, cyc);
    check("mult_min_hi", hi, 32'h4000_0000);
    check("mult_min_lo", lo, 32'h0);

    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_busy", cyc, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    do_op(3'd4, 32'd7, 32'd2, cyc);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    do_op(3'd3, 32'd7, 32'hFFFF_FFFE, cyc);
    check("div_negdivisor_lo", lo, 32'hFFFF_FFFD);
    check("div_negdivisor_hi", hi, 32'd1);

    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);

    do_op(3'd5, 32'h1234, 32'h0, cyc);
    check("mthi_busy", cyc, 32'd0);
    check("mthi_hi", hi, 32'h1234);
    do_op(3'd6, 32'h5678, 32'h0, cyc);
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);

    do_op(3'd4, 32'd7, 32'd0, cyc);
    check("div0_busy", cyc, 32'd10);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'h5678);

    // MULT 3*4 with an MTLO and an MTHI attempted while busy.
    mdop = 3'd1; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdop = 3'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 2) begin
        start = 1'b1; mdop = 3'd6; a = 32'hDEAD;
      end else if (cyc == 3) begin
        start = 1'b1; mdop = 3'd5; a = 32'hBEEF;
      end else begin
        start = 1'b0; mdop = 3'd0;
      end
      @(negedge clk);
      if (cyc == 2) check("busy_mtlo_ignored", lo, 32'h5678);
      if (cyc == 3) check("busy_mthi_ignored", hi, 32'h1234);
    end
    start = 1'b0; mdop = 3'd0;
    check("busy_ign_busy", cyc, 32'd5);
    check("busy_ign_hi", hi, 32'h0);
    check("busy_ign_lo", lo, 32'hC);

    // DIV 100/7 aborted by reset on busy cycle 4.
    mdop = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdop = 3'd0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    repeat (12) @(negedge clk);
    check("abort_no_commit_lo", lo, 32'h0);

    do_op(3'd1, 32'd2, 32'd3, cyc);
    check("post_abort_busy", cyc, 32'd5);
    check("post_abort_lo", lo, 32'd6);
    check("post_abort_hi", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
